uart_receiver: RTL and testbench

//  Serial-to-parallel UART receive path: 8N1 by default, LSB first, line idle high.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 25 ++
 rtl/uart_receiver.sv | 196 +++++++++++++++++++
 tb/tb_uart_receiver.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for the receive and transmit paths
// Holds the FSM state encoding, the default oversampling ratio and the idle line level.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } uart_state_t;

    localparam int   DEFAULT_OVERSAMPLE = 16;
    localparam logic LINE_IDLE          = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for an asynchronous single-bit input
// Ports: clk, rst (sync active-low), async_bit (raw input), sync_bit (synchronized output).
// RESET_VALUE sets both flops during reset so the output starts at a known line level.
module uart_rx_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_bit,
    output logic sync_bit
);

    logic meta_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q   <= RESET_VALUE;
            sync_bit <= RESET_VALUE;
        end else begin
            meta_q   <= async_bit;
            sync_bit <= meta_q;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampling UART receiver with valid/ready byte output
// Ports: clk, rst (sync active-low), rx_sample_tick (OVERSAMPLE x baud pulse), rx_pin (async line),
//        rx_data/rx_valid/rx_ready (byte handshake), frame_err and overrun (1-clk pulses),
//        parity_err (1-clk pulse, only when UART_RX_PARITY_EN is defined).
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit after the data bits.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_sample_tick,
    input  logic                 rx_pin,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 overrun,
    output logic                 parity_err
`else
    output logic                 overrun
`endif
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [SW-1:0] SAMP_MID = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_END = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    localparam uart_state_t AFTER_DATA = ST_PARITY;
`else
    localparam uart_state_t AFTER_DATA = ST_STOP;
`endif

    logic                 rx_s;
    uart_state_t          state_q, state_d;
    logic [SW-1:0]        samp_q, samp_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] rx_data_d;
    logic                 rx_valid_d;
    logic                 frame_err_d;
    logic                 overrun_d;
    logic                 load_ok;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 parity_err_d;
`endif

    uart_rx_sync #(
        .RESET_VALUE (LINE_IDLE)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .async_bit (rx_pin),
        .sync_bit  (rx_s)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            samp_q    <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            samp_q    <= samp_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            rx_data   <= rx_data_d;
            rx_valid  <= rx_valid_d;
            frame_err <= frame_err_d;
            overrun   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= par_bad_d;
            parity_err <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        samp_d      = samp_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data;
        rx_valid_d  = rx_valid;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif

        // A byte may load if the holding register is empty or being drained this very clk;
        // that makes accept-and-complete on the same clk a clean hand-over, not an overrun.
        load_ok = !rx_valid || rx_ready;
        if (rx_valid && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        if (rx_sample_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_s != LINE_IDLE) begin
                        state_d = ST_START;
                        samp_d  = '0;
                    end
                end
                ST_START: begin
                    if (samp_q == SAMP_MID) begin
                        if (rx_s == LINE_IDLE) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DATA;
                            samp_d  = '0;
                            bit_d   = '0;
                        end
                    end else begin
                        samp_d = samp_q + SW'(1);
                    end
                end
                ST_DATA: begin
                    if (samp_q == SAMP_END) begin
                        shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                        samp_d  = '0;
                        bit_d   = bit_q + BW'(1);
                        if (bit_q == BIT_LAST) begin
                            state_d = AFTER_DATA;
                        end
                    end else begin
                        samp_d = samp_q + SW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (samp_q == SAMP_END) begin
                        par_bad_d = (^shreg_q) ^ rx_s;
                        samp_d    = '0;
                        state_d   = ST_STOP;
                    end else begin
                        samp_d = samp_q + SW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    if (samp_q == SAMP_END) begin
                        samp_d = '0;
                        if (rx_s == LINE_IDLE) begin
                            state_d = ST_IDLE;
                            if (load_ok) begin
                                rx_data_d  = shreg_q;
                                rx_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                                parity_err_d = par_bad_q;
`endif
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            // Stop bit low: a held-low line (break) must not be re-read as
                            // back-to-back zero frames, so wait for the line to go idle.
                            frame_err_d = 1'b1;
                            state_d     = ST_WAIT_IDLE;
                        end
                    end else begin
                        samp_d = samp_q + SW'(1);
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rx_s == LINE_IDLE) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - scoreboard bench for uart_receiver driven by a serial tx model
module tb_uart_receiver;

    localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    localparam int RISE_LO = NB * BIT_CLKS + 24;
    localparam int RISE_HI = NB * BIT_CLKS + 56;

    typedef struct {
        logic [7:0] data;
        logic       perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_sample_tick;
    logic       rx_pin;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       par_flip = 1'b0;
`endif

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   ferr_seen = 0;
    int   ovr_seen = 0;
    int   cyc = 0;
    int   start_cyc = 0;

    uart_receiver #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_sample_tick (rx_sample_tick),
        .rx_pin         (rx_pin),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .frame_err      (frame_err),
`ifdef UART_RX_PARITY_EN
        .overrun        (overrun),
        .parity_err     (parity_err)
`else
        .overrun        (overrun)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One tick every 4 clks -> 16 ticks (64 clks) per bit.
    initial begin
        int tdiv;
        tdiv = 0;
        rx_sample_tick = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            tdiv = (tdiv + 1) % 4;
            rx_sample_tick = (tdiv == 0);
        end
    end

    // Serial line model: start, 8 data bits LSB first, optional even parity, stop held stop_len bits.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int stop_len);
        start_cyc = cyc;
        rx_pin = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_pin = d[i];
            wait_clks(BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        rx_pin = (^d) ^ par_flip;
        wait_clks(BIT_CLKS);
`endif
        rx_pin = stop_bit;
        wait_clks(BIT_CLKS * stop_len);
        rx_pin = 1'b1;
        wait_clks(BIT_CLKS);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic perr);
        exp_t e;
        e.data = d;
        e.perr = perr;
        exp_q.push_back(e);
    endtask

    // Monitor: samples on the falling edge, where inputs and outputs are both settled.
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (frame_err) ferr_seen++;
                if (overrun) ovr_seen++;
                if (rx_valid && !prev_valid) begin
                    check("rise_latency_in_window",
                          64'((cyc - start_cyc >= RISE_LO) && (cyc - start_cyc < RISE_HI)), 64'd1);
`ifdef UART_RX_PARITY_EN
                    if (exp_q.size() > 0) check("parity_err_at_rise", 64'(parity_err), 64'(exp_q[0].perr));
                end else if (parity_err) begin
                    check("parity_err_stray", 64'(parity_err), 64'd0);
`endif
                end
                if (rx_valid && rx_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", 64'(rx_data), 64'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_data", 64'(rx_data), 64'(e.data));
                    end
                end
            end
            prev_valid = rx_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int ferr_base;
        int ovr_base;
        bit done;

        rst = 1'b0;
        rx_pin = 1'b1;
        rx_ready = 1'b1;
        wait_clks(4);
        check("reset_rx_valid", 64'(rx_valid), 64'd0);
        check("reset_rx_data", 64'(rx_data), 64'd0);
        check("reset_frame_err", 64'(frame_err), 64'd0);
        check("reset_overrun", 64'(overrun), 64'd0);
        rst = 1'b1;
        wait_clks(20);

        // Clean 0xA5 frame.
        push_exp(8'hA5, 1'b0);
        send_frame(8'hA5, 1'b1, 1);
        wait_clks(BIT_CLKS);
        check("a5_delivered", 64'(exp_q.size()), 64'd0);
        check("a5_no_frame_err", 64'(ferr_seen), 64'd0);
        check("a5_no_overrun", 64'(ovr_seen), 64'd0);

        // 3-tick low glitch on the idle line.
        rx_pin = 1'b0;
        wait_clks(12);
        rx_pin = 1'b1;
        wait_clks(3 * BIT_CLKS);
        check("glitch_no_valid", 64'(rx_valid), 64'd0);
        check("glitch_no_frame_err", 64'(ferr_seen), 64'd0);

        // 0x3C with stop bit low for two bit times, then 0x55.
        send_frame(8'h3C, 1'b0, 2);
        check("break_frame_err_once", 64'(ferr_seen), 64'd1);
        check("break_no_valid", 64'(rx_valid), 64'd0);
        push_exp(8'h55, 1'b0);
        send_frame(8'h55, 1'b1, 1);
        wait_clks(BIT_CLKS);
        check("after_break_55", 64'(exp_q.size()), 64'd0);

        // Overrun: consumer stalled across two frames.
        rx_ready = 1'b0;
        push_exp(8'h11, 1'b0);
        send_frame(8'h11, 1'b1, 1);
        send_frame(8'h22, 1'b1, 1);
        wait_clks(10);
        check("overrun_data_held", 64'(rx_data), 64'h11);
        check("overrun_valid_held", 64'(rx_valid), 64'd1);
        check("overrun_once", 64'(ovr_seen), 64'd1);
        rx_ready = 1'b1;
        wait_clks(2);
        check("overrun_valid_cleared", 64'(rx_valid), 64'd0);
        check("overrun_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-DATA of 0xFF.
        ferr_base = ferr_seen;
        ovr_base = ovr_seen;
        fork
            send_frame(8'hFF, 1'b1, 1);
            begin
                wait_clks(4 * BIT_CLKS + 10);
                rst = 1'b0;
                wait_clks(3);
                check("midreset_rx_valid", 64'(rx_valid), 64'd0);
                check("midreset_rx_data", 64'(rx_data), 64'd0);
                check("midreset_frame_err", 64'(frame_err), 64'd0);
                check("midreset_overrun", 64'(overrun), 64'd0);
                rst = 1'b1;
            end
        join
        wait_clks(BIT_CLKS);
        check("midreset_no_byte", 64'(rx_valid), 64'd0);
        check("midreset_no_flags", 64'((ferr_seen - ferr_base) + (ovr_seen - ovr_base)), 64'd0);
        push_exp(8'h81, 1'b0);
        send_frame(8'h81, 1'b1, 1);
        wait_clks(BIT_CLKS);
        check("after_reset_81", 64'(exp_q.size()), 64'd0);

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight; sending parity 0 breaks even parity.
        par_flip = 1'b1;
        push_exp(8'h07, 1'b1);
        send_frame(8'h07, 1'b1, 1);
        par_flip = 1'b0;
        wait_clks(BIT_CLKS);
        check("parity_byte_delivered", 64'(exp_q.size()), 64'd0);
`endif

        // Random bytes with a randomly stalling consumer.
        ferr_base = ferr_seen;
        ovr_base = ovr_seen;
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 10; n++) begin
                    logic [7:0] d;
                    d = 8'($urandom);
                    wait_clks($urandom_range(0, 100));
                    push_exp(d, 1'b0);
                    send_frame(d, 1'b1, 1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    rx_ready = 1'($urandom_range(0, 1));
                    wait_clks(1);
                end
            end
        join
        rx_ready = 1'b1;
        wait_clks(BIT_CLKS);
        check("random_all_delivered", 64'(exp_q.size()), 64'd0);
        check("random_no_flags", 64'((ferr_seen - ferr_base) + (ovr_seen - ovr_base)), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
